// File: rtl/controlador_turnos.sv
// Tic-tac-toe turn controller: validates moves, keeps the 3x3 board, detects
// the winner or a draw one cycle after each accepted move, and tallies wins.
module controlador_turnos #(
  parameter int WIN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nuevo_juego,
  input  logic             mov_valido,
  input  logic [3:0]       mov_pos,
  output logic [1:0]       pos1,
  output logic [1:0]       pos2,
  output logic [1:0]       pos3,
  output logic [1:0]       pos4,
  output logic [1:0]       pos5,
  output logic [1:0]       pos6,
  output logic [1:0]       pos7,
  output logic [1:0]       pos8,
  output logic [1:0]       pos9,
  output logic             turno,
  output logic             mov_error,
  output logic             gana_x,
  output logic             gana_o,
  output logic             empate,
  output logic             fin_juego,
  output logic [3:0]       jugadas,
  output logic [WIN_W-1:0] victorias_x,
  output logic [WIN_W-1:0] victorias_o
);

  typedef enum logic [2:0] {
    TURNO_X,
    TURNO_O,
    EVALUA,
    GANA_X,
    GANA_O,
    EMPATE
  } state_t;

  localparam logic [1:0] VACIA = 2'b00;
  localparam logic [1:0] FICHA_X = 2'b01;
  localparam logic [1:0] FICHA_O = 2'b10;

  state_t     state, state_next;
  logic [1:0] board [9];
  logic       ultimo;        // last mover: 0 = X, 1 = O
  logic       en_turno;
  logic       pos_ok;
  logic       libre;
  logic       aceptar;
  logic       rechazar;
  logic       gana;
  logic       lleno;
  logic [1:0] ficha_mov;
  logic [1:0] ficha_ultimo;

  function automatic logic linea(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic [1:0] s);
    return (a == s) && (b == s) && (c == s);
  endfunction

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    en_turno     = (state == TURNO_X) || (state == TURNO_O);
    pos_ok       = (mov_pos >= 4'd1) && (mov_pos <= 4'd9);
    libre        = 1'b0;
    lleno        = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (mov_pos == 4'(i + 1)) libre = (board[i] == VACIA);
      if (board[i] == VACIA) lleno = 1'b0;
    end
    aceptar      = en_turno && mov_valido && !nuevo_juego && pos_ok && libre;
    rechazar     = en_turno && mov_valido && !nuevo_juego && !(pos_ok && libre);
    ficha_mov    = (state == TURNO_O) ? FICHA_O : FICHA_X;
    ficha_ultimo = ultimo ? FICHA_O : FICHA_X;
    gana = linea(board[0], board[1], board[2], ficha_ultimo) ||
           linea(board[3], board[4], board[5], ficha_ultimo) ||
           linea(board[6], board[7], board[8], ficha_ultimo) ||
           linea(board[0], board[3], board[6], ficha_ultimo) ||
           linea(board[1], board[4], board[7], ficha_ultimo) ||
           linea(board[2], board[5], board[8], ficha_ultimo) ||
           linea(board[0], board[4], board[8], ficha_ultimo) ||
           linea(board[2], board[4], board[6], ficha_ultimo);

    state_next = state;
    if (nuevo_juego) begin
      state_next = TURNO_X;
    end else begin
      unique case (state)
        TURNO_X, TURNO_O: if (aceptar) state_next = EVALUA;
        // A win is checked before fullness so a ninth-move win beats a draw.
        EVALUA: begin
          if (gana)       state_next = ultimo ? GANA_O : GANA_X;
          else if (lleno) state_next = EMPATE;
          else            state_next = ultimo ? TURNO_X : TURNO_O;
        end
        default: state_next = state;
      endcase
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order. The board is a
  // handful of flops, not a RAM, so it is cleared by reset like any register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= TURNO_X;
      ultimo      <= 1'b0;
      jugadas     <= 4'd0;
      mov_error   <= 1'b0;
      victorias_x <= '0;
      victorias_o <= '0;
      for (int i = 0; i < 9; i++) board[i] <= VACIA;
    end else begin
      state     <= state_next;
      mov_error <= rechazar;
      if (nuevo_juego) begin
        jugadas <= 4'd0;
        for (int i = 0; i < 9; i++) board[i] <= VACIA;
      end else if (aceptar) begin
        jugadas <= jugadas + 4'd1;
        ultimo  <= (state == TURNO_O);
        for (int i = 0; i < 9; i++)
          if (mov_pos == 4'(i + 1)) board[i] <= ficha_mov;
      end
      if (state == EVALUA && state_next == GANA_X && victorias_x != '1)
        victorias_x <= victorias_x + WIN_W'(1);
      if (state == EVALUA && state_next == GANA_O && victorias_o != '1)
        victorias_o <= victorias_o + WIN_W'(1);
    end
  end

  always_comb begin
    unique case (state)
      TURNO_X: turno = 1'b0;
      TURNO_O: turno = 1'b1;
      default: turno = ultimo;
    endcase
  end

  assign gana_x    = (state == GANA_X);
  assign gana_o    = (state == GANA_O);
  assign empate    = (state == EMPATE);
  assign fin_juego = gana_x | gana_o | empate;

  assign pos1 = board[0];
  assign pos2 = board[1];
  assign pos3 = board[2];
  assign pos4 = board[3];
  assign pos5 = board[4];
  assign pos6 = board[5];
  assign pos7 = board[6];
  assign pos8 = board[7];
  assign pos9 = board[8];

endmodule

// File: tb/tb_controlador_turnos.sv
// Bench for controlador_turnos: scripted vector table, hand-written game
// sequences, then random play checked against a rule-level game model.
module tb_controlador_turnos;

  localparam int WIN_W = 4;
  localparam int WIN_MAX = (1 << WIN_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             nuevo_juego = 1'b0;
  logic             mov_valido = 1'b0;
  logic [3:0]       mov_pos = 4'd0;
  logic [1:0]       pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic             turno, mov_error, gana_x, gana_o, empate, fin_juego;
  logic [3:0]       jugadas;
  logic [WIN_W-1:0] victorias_x, victorias_o;

  int n_cmp = 0;
  int n_fail = 0;

  controlador_turnos #(.WIN_W(WIN_W)) dut (
    .clk(clk), .reset(reset), .nuevo_juego(nuevo_juego),
    .mov_valido(mov_valido), .mov_pos(mov_pos),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .turno(turno), .mov_error(mov_error), .gana_x(gana_x), .gana_o(gana_o),
    .empate(empate), .fin_juego(fin_juego), .jugadas(jugadas),
    .victorias_x(victorias_x), .victorias_o(victorias_o)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input string b, input int t, input int e,
                                input int gx, input int go, input int em,
                                input int fin, input int j, input int vx,
                                input int vo);
    return $sformatf("b=%s t=%0d e=%0d gx=%0d go=%0d em=%0d fin=%0d j=%0d vx=%0d vo=%0d",
                     b, t, e, gx, go, em, fin, j, vx, vo);
  endfunction

  function automatic string cell_char(input logic [1:0] c);
    return (c == 2'b00) ? "." : (c == 2'b01) ? "X" : (c == 2'b10) ? "O" : "?";
  endfunction

  function automatic string dut_obs();
    string b;
    b = {cell_char(pos1), cell_char(pos2), cell_char(pos3), cell_char(pos4),
         cell_char(pos5), cell_char(pos6), cell_char(pos7), cell_char(pos8),
         cell_char(pos9)};
    return fmt(b, int'(turno), int'(mov_error), int'(gana_x), int'(gana_o),
               int'(empate), int'(fin_juego), int'(jugadas),
               int'(victorias_x), int'(victorias_o));
  endfunction

  task automatic check(input string name, input string got, input string exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got [%s] expected [%s]", name, got, exp);
    end
  endtask

  task automatic step(input bit nj, input bit mv, input logic [3:0] p);
    nuevo_juego = nj;
    mov_valido  = mv;
    mov_pos     = p;
    @(posedge clk);
    #1;
    nuevo_juego = 1'b0;
    mov_valido  = 1'b0;
    mov_pos     = 4'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic play(input logic [3:0] p);
    step(1'b0, 1'b1, p);
    step(1'b0, 1'b0, 4'd0);
  endtask

  // Rule-level reference: cells as X/O/empty, a line table, a pending-check
  // flag for the one-cycle evaluation delay, and a result code.
  int lineas [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int m_cell [9];       // 0 empty, 1 X, 2 O
  int m_jug, m_res, m_vx, m_vo;  // m_res: 0 playing, 1 X won, 2 O won, 3 draw
  bit m_pend, m_err, m_to_move, m_mover;

  function automatic void model_clear_board();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_jug = 0; m_res = 0; m_pend = 0; m_err = 0; m_to_move = 0;
  endfunction

  function automatic void model_reset();
    model_clear_board();
    m_vx = 0; m_vo = 0; m_mover = 0;
  endfunction

  function automatic void model_step(input bit nj, input bit mv, input int p);
    m_err = 0;
    if (nj) begin
      model_clear_board();
    end else if (m_pend) begin
      int who;
      bit won;
      m_pend = 0;
      who = m_mover ? 2 : 1;
      won = 0;
      foreach (lineas[l])
        if (m_cell[lineas[l][0]] == who && m_cell[lineas[l][1]] == who &&
            m_cell[lineas[l][2]] == who) won = 1;
      if (won) begin
        m_res = who;
        if (who == 1 && m_vx < WIN_MAX) m_vx++;
        if (who == 2 && m_vo < WIN_MAX) m_vo++;
      end else if (m_jug == 9) begin
        m_res = 3;
      end else begin
        m_to_move = !m_mover;
      end
    end else if (m_res == 0 && mv) begin
      if (p >= 1 && p <= 9 && m_cell[p-1] == 0) begin
        m_cell[p-1] = m_to_move ? 2 : 1;
        m_jug++;
        m_mover = m_to_move;
        m_pend = 1;
      end else begin
        m_err = 1;
      end
    end
  endfunction

  function automatic string model_obs();
    string b = "";
    for (int i = 0; i < 9; i++)
      b = {b, (m_cell[i] == 0) ? "." : (m_cell[i] == 1) ? "X" : "O"};
    return fmt(b, (m_res == 0 && !m_pend) ? int'(m_to_move) : int'(m_mover),
               int'(m_err), int'(m_res == 1), int'(m_res == 2),
               int'(m_res == 3), int'(m_res != 0), m_jug, m_vx, m_vo);
  endfunction

  typedef struct {
    bit         nj;
    bit         mv;
    logic [3:0] pos;
    string      board;
    bit         turno;
    bit         err;
    bit         gx;
    int         jug;
    int         vx;
  } vec_t;

  vec_t tabla [$];

  initial begin
    tabla.push_back(vec_t'{0, 1, 4'd0,  ".........", 0, 1, 0, 0, 0}); // pos 0 rejected
    tabla.push_back(vec_t'{0, 0, 4'd0,  ".........", 0, 0, 0, 0, 0}); // error lasts one cycle
    tabla.push_back(vec_t'{0, 1, 4'd12, ".........", 0, 1, 0, 0, 0}); // pos 12 rejected
    tabla.push_back(vec_t'{0, 1, 4'd5,  "....X....", 0, 0, 0, 1, 0}); // X5, EVALUA keeps X
    tabla.push_back(vec_t'{0, 0, 4'd0,  "....X....", 1, 0, 0, 1, 0}); // O to move
    tabla.push_back(vec_t'{0, 1, 4'd5,  "....X....", 1, 1, 0, 1, 0}); // occupied
    tabla.push_back(vec_t'{0, 0, 4'd0,  "....X....", 1, 0, 0, 1, 0});
    tabla.push_back(vec_t'{1, 0, 4'd0,  ".........", 0, 0, 0, 0, 0}); // new game
    tabla.push_back(vec_t'{0, 1, 4'd1,  "X........", 0, 0, 0, 1, 0});
    tabla.push_back(vec_t'{0, 1, 4'd7,  "X........", 1, 0, 0, 1, 0}); // ignored in EVALUA
    tabla.push_back(vec_t'{0, 1, 4'd4,  "X..O.....", 1, 0, 0, 2, 0});
    tabla.push_back(vec_t'{0, 0, 4'd0,  "X..O.....", 0, 0, 0, 2, 0});
    tabla.push_back(vec_t'{0, 1, 4'd2,  "XX.O.....", 0, 0, 0, 3, 0});
    tabla.push_back(vec_t'{0, 0, 4'd0,  "XX.O.....", 1, 0, 0, 3, 0});
    tabla.push_back(vec_t'{0, 1, 4'd5,  "XX.OO....", 1, 0, 0, 4, 0});
    tabla.push_back(vec_t'{0, 0, 4'd0,  "XX.OO....", 0, 0, 0, 4, 0});
    tabla.push_back(vec_t'{0, 1, 4'd3,  "XXXOO....", 0, 0, 0, 5, 0}); // winning edge
    tabla.push_back(vec_t'{0, 0, 4'd0,  "XXXOO....", 0, 0, 1, 5, 1}); // gana_x next edge
    tabla.push_back(vec_t'{0, 1, 4'd9,  "XXXOO....", 0, 0, 1, 5, 1}); // ignored when over
    tabla.push_back(vec_t'{1, 1, 4'd9,  ".........", 0, 0, 0, 0, 1}); // new game wins, no write
    tabla.push_back(vec_t'{0, 0, 4'd0,  ".........", 0, 0, 0, 0, 1});

    do_reset();
    check("reset_state", dut_obs(), fmt(".........", 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tabla[k]) begin
      step(tabla[k].nj, tabla[k].mv, tabla[k].pos);
      check($sformatf("vector_%0d", k), dut_obs(),
            fmt(tabla[k].board, tabla[k].turno, tabla[k].err, tabla[k].gx, 0, 0,
                tabla[k].gx, tabla[k].jug, tabla[k].vx, 0));
    end

    // Full board without a line ends in a draw.
    step(1'b1, 1'b0, 4'd0);
    play(4'd5); play(4'd1); play(4'd3); play(4'd7); play(4'd4);
    play(4'd6); play(4'd2); play(4'd8); play(4'd9);
    check("draw", dut_obs(), fmt("OXXXXOOOX", 0, 0, 0, 0, 1, 1, 9, 1, 0));

    // Win counter saturates.
    repeat (16) begin
      step(1'b1, 1'b0, 4'd0);
      play(4'd1); play(4'd4); play(4'd2); play(4'd5); play(4'd3);
    end
    check("x_saturates", dut_obs(), fmt("XXXOO....", 0, 0, 1, 0, 0, 1, 5, WIN_MAX, 0));

    step(1'b1, 1'b0, 4'd0);
    play(4'd1); play(4'd4); play(4'd2); play(4'd5); play(4'd7); play(4'd6);
    check("o_wins", dut_obs(), fmt("XX.OOOX..", 1, 0, 0, 1, 0, 1, 6, WIN_MAX, 1));

    // Reset during the evaluation of a winning move aborts the game.
    step(1'b1, 1'b0, 4'd0);
    play(4'd1); play(4'd4); play(4'd2); play(4'd5);
    step(1'b0, 1'b1, 4'd3);
    do_reset();
    check("reset_in_evalua", dut_obs(), fmt(".........", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b0, 4'd0);
    check("after_reset_idle", dut_obs(), fmt(".........", 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Random play against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      bit         nj, mv;
      logic [3:0] p;
      nj = ($urandom_range(0, 39) == 0);
      mv = ($urandom_range(0, 9) < 6);
      p  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                       : 4'($urandom_range(0, 9));
      step(nj, mv, p);
      model_step(nj, mv, int'(p));
      check($sformatf("random_%0d", c), dut_obs(), model_obs());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
